// File: rtl/bist_scan_readout.sv
`default_nettype none
// ============================================================================
//  Module      : bist_scan_readout
//  Description : Reads the BIST capture buffer plus the lock-time results and
//                serializes them MSB first into a framed bit stream:
//                header | locktime | comp_locktime | length | entries | parity
//                The stream is offered on a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_scan_readout #(
    parameter int         REGISTER_LENGTH = 30,
    parameter int         ENTRY_WIDTH     = 81,
    parameter logic [7:0] HEADER_PATTERN  = 8'hA5
) (
    input  logic                   ref_clk_bist,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [10:0]            locktime,
    input  logic [10:0]            computational_locktime,
    output logic [6:0]             rd_index,
    input  logic [ENTRY_WIDTH-1:0] rd_data,
    output logic                   scan_out,
    output logic                   scan_valid,
    input  logic                   scan_ready,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int C_RESULT_BITS = 29;
    // Shift register must hold the widest segment (an entry or the result block).
    localparam int C_SHW  = (ENTRY_WIDTH > C_RESULT_BITS) ? ENTRY_WIDTH : C_RESULT_BITS;
    localparam int C_CNTW = $clog2(C_SHW + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_RESULT = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_ENTRY  = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;

    localparam logic [6:0]      C_LAST_INDEX = 7'(REGISTER_LENGTH - 1);
    localparam logic [6:0]      C_LEN_FIELD  = 7'(REGISTER_LENGTH);
    localparam logic [C_CNTW-1:0] C_HDR_LAST = C_CNTW'(7);
    localparam logic [C_CNTW-1:0] C_RES_LAST = C_CNTW'(C_RESULT_BITS - 1);
    localparam logic [C_CNTW-1:0] C_ENT_LAST = C_CNTW'(ENTRY_WIDTH - 1);

    logic [2:0]        state_q,      state_d;
    logic [C_SHW-1:0]  shift_q,      shift_d;
    logic [C_CNTW-1:0] cnt_q,        cnt_d;
    logic [6:0]        rd_index_q,   rd_index_d;
    logic [21:0]       hold_q,       hold_d;
    logic              parity_q,     parity_d;
    logic              scan_valid_q, scan_valid_d;
    logic              busy_q,       busy_d;
    logic              frame_done_q, frame_done_d;
    logic              accept;

    // Next-state logic: every serial advance is gated by an accepted bit.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        rd_index_d   = rd_index_q;
        hold_d       = hold_q;
        parity_d     = parity_q;
        frame_done_d = 1'b0;
        accept       = scan_valid_q & scan_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d                  = S_HEADER;
                    hold_d                   = {locktime, computational_locktime};
                    shift_d                  = '0;
                    shift_d[C_SHW-1 -: 8]    = HEADER_PATTERN;
                    rd_index_d               = 7'd0;
                    cnt_d                    = '0;
                    parity_d                 = 1'b0;
                end
            end
            S_HEADER: begin
                if (accept) begin
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == C_HDR_LAST) begin
                        state_d                           = S_RESULT;
                        cnt_d                             = '0;
                        shift_d                           = '0;
                        shift_d[C_SHW-1 -: C_RESULT_BITS] = {hold_q, C_LEN_FIELD};
                    end
                end
            end
            S_RESULT: begin
                if (accept) begin
                    parity_d = parity_q ^ shift_q[C_SHW-1];
                    shift_d  = shift_q << 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == C_RES_LAST) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                    end
                end
            end
            S_LOAD: begin
                // rd_data is valid for the current rd_index; capture it here.
                state_d                         = S_ENTRY;
                cnt_d                           = '0;
                shift_d                         = '0;
                shift_d[C_SHW-1 -: ENTRY_WIDTH] = rd_data;
            end
            S_ENTRY: begin
                if (accept) begin
                    parity_d = parity_q ^ shift_q[C_SHW-1];
                    shift_d  = shift_q << 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == C_ENT_LAST) begin
                        cnt_d = '0;
                        if (rd_index_q < C_LAST_INDEX) begin
                            rd_index_d = rd_index_q + 7'd1;
                            state_d    = S_LOAD;
                        end else begin
                            // Parity includes the entry bit being accepted now.
                            state_d          = S_PARITY;
                            shift_d          = '0;
                            shift_d[C_SHW-1] = parity_d;
                        end
                    end
                end
            end
            S_PARITY: begin
                if (accept) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                    parity_d     = 1'b0;
                    shift_d      = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_d      = S_IDLE;
            shift_d      = '0;
            cnt_d        = '0;
            rd_index_d   = 7'd0;
            hold_d       = hold_q;
            parity_d     = 1'b0;
            frame_done_d = 1'b0;
        end

        scan_valid_d = (state_d == S_HEADER) || (state_d == S_RESULT) ||
                       (state_d == S_ENTRY)  || (state_d == S_PARITY);
        busy_d       = (state_d != S_IDLE);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge ref_clk_bist or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            rd_index_q   <= 7'd0;
            hold_q       <= '0;
            parity_q     <= 1'b0;
            scan_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            rd_index_q   <= rd_index_d;
            hold_q       <= hold_d;
            parity_q     <= parity_d;
            scan_valid_q <= scan_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_index   = rd_index_q;
    assign scan_out   = shift_q[C_SHW-1];
    assign scan_valid = scan_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_scan_readout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bist_scan_readout
//  Description : Self-checking bench for bist_scan_readout (default build and
//                a one-entry build with an all-ones entry).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_scan_readout;

    localparam int BUDGET = 20000;

    logic        clk;
    logic        reset_n;
    logic        start_r;
    logic        abort_r;
    logic        scan_ready;
    logic [10:0] lt_r;
    logic [10:0] clt_r;
    bit          sel_r;

    logic [6:0]  a_rd_index, b_rd_index;
    logic [80:0] a_rd_data,  b_rd_data;
    logic        a_scan_out, a_scan_valid, a_busy, a_frame_done;
    logic        b_scan_out, b_scan_valid, b_busy, b_frame_done;
    logic        a_start, b_start;

    int n_cmp = 0;
    int n_err = 0;

    bit got_q[$];
    bit exp_q[$];
    int stab_err, busy_err, idx_err;

    // Capture buffers: default build holds k in the low 7 bits; second is all ones.
    assign a_rd_data = {74'd0, a_rd_index};
    assign b_rd_data = '1;
    assign a_start   = start_r & ~sel_r;
    assign b_start   = start_r &  sel_r;

    wire       c_valid = sel_r ? b_scan_valid : a_scan_valid;
    wire       c_out   = sel_r ? b_scan_out   : a_scan_out;
    wire       c_busy  = sel_r ? b_busy       : a_busy;
    wire       c_done  = sel_r ? b_frame_done : a_frame_done;
    wire [6:0] c_index = sel_r ? b_rd_index   : a_rd_index;

    bist_scan_readout u_dut_a (
        .ref_clk_bist(clk), .reset(reset_n), .start(a_start), .abort(abort_r),
        .locktime(lt_r), .computational_locktime(clt_r),
        .rd_index(a_rd_index), .rd_data(a_rd_data),
        .scan_out(a_scan_out), .scan_valid(a_scan_valid), .scan_ready(scan_ready),
        .busy(a_busy), .frame_done(a_frame_done)
    );

    bist_scan_readout #(.REGISTER_LENGTH(1)) u_dut_b (
        .ref_clk_bist(clk), .reset(reset_n), .start(b_start), .abort(abort_r),
        .locktime(lt_r), .computational_locktime(clt_r),
        .rd_index(b_rd_index), .rd_data(b_rd_data),
        .scan_out(b_scan_out), .scan_valid(b_scan_valid), .scan_ready(scan_ready),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference frame built straight from the frame format.
    task automatic build_expected(input bit sel, input logic [10:0] lt, input logic [10:0] clt);
        logic [7:0]  hdr;
        logic [28:0] res;
        logic [80:0] e;
        int          rl;
        bit          p;
        rl  = sel ? 1 : 30;
        hdr = 8'hA5;
        res = {lt, clt, 7'(rl)};
        p   = 1'b0;
        exp_q.delete();
        for (int i = 7; i >= 0; i--) exp_q.push_back(hdr[i]);
        for (int i = 28; i >= 0; i--) begin
            exp_q.push_back(res[i]);
            p ^= res[i];
        end
        for (int k = 0; k < rl; k++) begin
            e = sel ? '1 : 81'(k);
            for (int i = 80; i >= 0; i--) begin
                exp_q.push_back(e[i]);
                p ^= e[i];
            end
        end
        exp_q.push_back(p);
    endtask

    // Runs one frame with ready asserted pct% of cycles; optionally re-pulses
    // start once when restart_at bits have been accepted.
    task automatic run_frame(input bit sel, input logic [10:0] lt, input logic [10:0] clt,
                             input int pct, input int restart_at, output int edges);
        bit prev_hold, prev_bit, fired, done;
        int max_idx;
        max_idx   = sel ? 0 : 29;
        got_q.delete();
        stab_err  = 0;
        busy_err  = 0;
        idx_err   = 0;
        prev_hold = 1'b0;
        prev_bit  = 1'b0;
        fired     = 1'b0;
        done      = 1'b0;
        edges     = -1;
        @(negedge clk);
        sel_r   = sel;
        lt_r    = lt;
        clt_r   = clt;
        start_r = 1'b1;
        scan_ready = 1'b0;
        for (int it = 1; it <= BUDGET; it++) begin
            @(negedge clk);
            if (prev_hold && (!c_valid || c_out !== prev_bit)) stab_err++;
            if (c_done) begin
                edges = it - 1;
                done  = 1'b1;
                if (c_busy) busy_err++;
                start_r = 1'b0;
                break;
            end
            if (!c_busy) busy_err++;
            if (int'(c_index) > max_idx) idx_err++;
            scan_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            if (!fired && restart_at >= 0 && got_q.size() == restart_at) begin
                start_r = 1'b1;
                fired   = 1'b1;
            end else begin
                start_r = 1'b0;
            end
            if (c_valid && scan_ready) got_q.push_back(c_out);
            prev_hold = c_valid && !scan_ready;
            prev_bit  = c_out;
        end
        check("frame_timeout", {63'd0, done}, 64'd1);
        @(negedge clk);
        check("frame_done_width", {63'd0, c_done}, 64'd0);
        check("busy_after_done", {63'd0, c_busy}, 64'd0);
    endtask

    typedef struct {
        bit          sel;
        logic [10:0] lt;
        logic [10:0] clt;
        int          pct;
        int          restart_at;
        logic [36:0] first37;
        bit          parity;
        int          nbits;
        int          edges;   // 0: not checked (throttled ready)
    } vec_t;

    vec_t tbl[5];

    task automatic check_stream(input vec_t v, input int edges);
        int          bad;
        logic [36:0] f;
        bad = 0;
        f   = '0;
        build_expected(v.sel, v.lt, v.clt);
        check("frame_bits", 64'(got_q.size()), 64'(v.nbits));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) bad++;
        if (got_q.size() != exp_q.size()) bad++;
        check("stream_bit_errors", 64'(bad), 64'd0);
        if (got_q.size() >= 37)
            for (int i = 0; i < 37; i++) f[36-i] = got_q[i];
        check("header_result", 64'(f), 64'(v.first37));
        if (got_q.size() > 0)
            check("parity_bit", {63'd0, got_q[got_q.size()-1]}, {63'd0, v.parity});
        if (v.edges != 0) check("frame_cycles", 64'(edges), 64'(v.edges));
        check("stable_while_stalled", 64'(stab_err), 64'd0);
        check("busy_during_frame", 64'(busy_err), 64'd0);
        check("rd_index_range", 64'(idx_err), 64'd0);
    endtask

    initial begin
        int   edges;
        bit   ok;
        vec_t v;

        // Parity sums: entries 0..29 contribute 71 ones; length 30 contributes 4.
        // One-entry build: 81 entry ones + one 1 from 7'd1 -> even -> parity 0.
        tbl[0] = '{0, 11'd37,   11'd500, 100, -1,  {8'hA5, 11'd37,   11'd500, 7'd30}, 1'b0, 2468, 2498};
        tbl[1] = '{0, 11'd37,   11'd500, 30,  100, {8'hA5, 11'd37,   11'd500, 7'd30}, 1'b0, 2468, 0};
        tbl[2] = '{0, 11'h7FF,  11'd1,   100, -1,  {8'hA5, 11'h7FF,  11'd1,   7'd30}, 1'b1, 2468, 2498};
        tbl[3] = '{0, 11'd0,    11'd0,   50,  -1,  {8'hA5, 11'd0,    11'd0,   7'd30}, 1'b1, 2468, 0};
        tbl[4] = '{1, 11'd0,    11'd0,   100, -1,  {8'hA5, 11'd0,    11'd0,   7'd1},  1'b0, 119,  120};

        reset_n = 1'b0; start_r = 1'b0; abort_r = 1'b0; scan_ready = 1'b0;
        lt_r = '0; clt_r = '0; sel_r = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_index",   64'(a_rd_index),  64'd0);
        check("rst_scan_out",   {63'd0, a_scan_out},   64'd0);
        check("rst_scan_valid", {63'd0, a_scan_valid}, 64'd0);
        check("rst_busy",       {63'd0, a_busy},       64'd0);
        check("rst_frame_done", {63'd0, a_frame_done}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            v = tbl[i];
            run_frame(v.sel, v.lt, v.clt, v.pct, v.restart_at, edges);
            check_stream(v, edges);
        end

        // start together with abort in IDLE: abort wins.
        sel_r = 1'b0;
        @(negedge clk);
        start_r = 1'b1; abort_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0; abort_r = 1'b0;
        check("start_abort_busy",  {63'd0, a_busy},       64'd0);
        check("start_abort_valid", {63'd0, a_scan_valid}, 64'd0);

        // Abort during entry 5.
        lt_r = 11'd37; clt_r = 11'd500; scan_ready = 1'b1;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        ok = 1'b0;
        for (int it = 0; it < BUDGET; it++) begin
            if (a_rd_index == 7'd5 && a_scan_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("reach_entry5", {63'd0, ok}, 64'd1);
        repeat (10) @(negedge clk);
        abort_r = 1'b1;
        @(negedge clk);
        abort_r = 1'b0;
        check("abort_valid",      {63'd0, a_scan_valid}, 64'd0);
        check("abort_busy",       {63'd0, a_busy},       64'd0);
        check("abort_rd_index",   64'(a_rd_index),       64'd0);
        check("abort_frame_done", {63'd0, a_frame_done}, 64'd0);
        edges = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_frame_done || a_busy || a_scan_valid) edges++;
        end
        check("abort_stays_idle", 64'(edges), 64'd0);
        run_frame(tbl[0].sel, tbl[0].lt, tbl[0].clt, 100, -1, edges);
        check_stream(tbl[0], edges);

        // Asynchronous reset between clock edges while in an entry.
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        ok = 1'b0;
        for (int it = 0; it < BUDGET; it++) begin
            if (a_rd_index == 7'd2 && a_scan_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("reach_entry2", {63'd0, ok}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_rd_index",   64'(a_rd_index),       64'd0);
        check("arst_scan_out",   {63'd0, a_scan_out},   64'd0);
        check("arst_scan_valid", {63'd0, a_scan_valid}, 64'd0);
        check("arst_busy",       {63'd0, a_busy},       64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("arst_no_resume", {63'd0, a_busy | a_scan_valid}, 64'd0);
        run_frame(tbl[2].sel, tbl[2].lt, tbl[2].clt, 100, -1, edges);
        check_stream(tbl[2], edges);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
